motion_bbox: RTL
================

MOTION_BBOX -- requirements
Module: motion_bbox

Interface
REQ-001 SHALL have parameter X_W, default 12: width of the column and row counters.
REQ-002 SHALL have parameter MIN_PIX, default 64: minimum set-pixel count per frame to declare motion.
REQ-003 SHALL have parameter BOX_COLOR, default 24'hFF0000: overlay colour.
REQ-004 SHALL have port pclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous to pclk and active-high.
REQ-006 SHALL have port s_pData, input, 24 bits: binary mask pixel from the threshold stage (all-ones = set, all-zeros = clear).
REQ-007 SHALL have ports s_pVDE, s_pHSync, s_pVSync, input, 1 bit each: data-enable and syncs, with VSync active-high.
REQ-008 SHALL have port m_pData, output, 24 bits: pass-through or overlaid pixel.
REQ-009 SHALL have ports m_pVDE, m_pHSync, m_pVSync, output, 1 bit each: delayed control signals.
REQ-010 SHALL have ports box_xmin, box_xmax, box_ymin, box_ymax, output, X_W bits each: bounding box of the last completed frame.
REQ-011 SHALL have port pix_count, output, 2*X_W bits: set pixels counted in the last completed frame.
REQ-012 SHALL have ports motion_det and box_valid, output, 1 bit each.
REQ-013 SHALL have port frame_done, output, 1 bit: single-cycle pulse when the frame results update.

Function
REQ-014 SHALL treat a pixel as set when s_pVDE=1 and s_pData != 0.
REQ-015 SHALL keep column counter x: incremented on each VDE=1 cycle, cleared on the VDE falling edge, saturating at 2^X_W-1.
REQ-016 SHALL keep row counter y: incremented on each VDE falling edge, cleared at frame start, saturating at 2^X_W-1.
REQ-017 SHALL run an FSM with states SYNC, ACTIVE and LATCH.
- SYNC: discards data and moves to ACTIVE on a VSync rising edge.
- ACTIVE: accumulates statistics and moves to LATCH on a VSync rising edge.
- LATCH: stays one cycle, then moves to ACTIVE.
REQ-018 SHALL, in ACTIVE, update running xmin, xmax, ymin and ymax for every set pixel using the current x and y.
REQ-019 SHALL, in ACTIVE, increment the running count for every set pixel, saturating at all-ones.
REQ-020 SHALL, in LATCH, copy the running values to the box_* and pix_count outputs, pulse frame_done for that cycle, and clear the running values for the next frame (min fields to all-ones, max and count fields to 0, x and y to 0).
REQ-021 SHALL, in LATCH, set motion_det = (count >= MIN_PIX) and box_valid = (count != 0).
REQ-022 SHALL, for a frame with zero set pixels, drive all box_* outputs to 0 and box_valid=0.
REQ-023 SHALL, when a VSync rising edge and a set pixel occur in the same cycle, include that pixel in the closing frame.
REQ-024 SHALL delay m_pVDE, m_pHSync and m_pVSync by exactly 1 cycle relative to the inputs.
REQ-025 SHALL drive m_pData 1 cycle after s_pData, and drive it to 0 when s_pVDE=0.
REQ-026 SHALL hold the last latched results constant between frame_done pulses.

Reset
REQ-027 SHALL, while rst=1, force all outputs to 0, the FSM to SYNC, and all counters and running values to their cleared state.
REQ-028 SHALL, when rst is asserted mid-frame, discard the partial frame so that no frame_done is issued for it.

Configuration
REQ-029 SHALL compile the box overlay in when macro MOTION_BBOX_OVERLAY_EN is defined.
- The overlay replaces m_pData with BOX_COLOR when box_valid=1 and the current (x,y) lies on the perimeter of the latched box.
- Perimeter: x equals xmin or xmax with y between ymin and ymax inclusive, or y equals ymin or ymax with x between xmin and xmax inclusive.
REQ-030 SHALL, when MOTION_BBOX_OVERLAY_EN is not defined, make m_pData the pure 1-cycle-delayed mask with no overlay logic present.

Verification
REQ-031 SHALL cover: 16x8 frame with a set 4x3 block at x=5..8, y=2..4, MIN_PIX=10 -> after the next VSync rise: frame_done pulse, box=(5,8,2,4), pix_count=12, motion_det=1, box_valid=1.
REQ-032 SHALL cover: an all-clear frame -> pix_count=0, box_valid=0, motion_det=0, box_* all 0.
REQ-033 SHALL cover: a single set pixel at (15,7) with MIN_PIX=64 -> box=(15,15,7,7), box_valid=1, motion_det=0.
REQ-034 SHALL cover: rst pulsed mid-frame, then one full frame -> no frame_done until the second VSync rise after reset, and results reflect only the post-reset frame.
REQ-035 SHALL cover: with MOTION_BBOX_OVERLAY_EN defined, after REQ-031's frame -> next frame's m_pData equals FF0000 at (5,2), (8,4), (6,2) and (5,3), and passes the mask through at (6,3).
REQ-036 SHALL cover: a set pixel coincident with the VSync rising edge -> counted in the closing frame's pix_count.

Source files
------------

// File: rtl/motion_bbox.sv
// Motion bounding box over a binary mask video stream; 1-cycle video latency, no backpressure.
// Perimeter overlay of the latched box is compiled in only with MOTION_BBOX_OVERLAY_EN.
`timescale 1ns/1ps
module motion_bbox #(
  parameter int          X_W       = 12,
  parameter int          MIN_PIX   = 64,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [23:0]      s_pData,
  input  logic             s_pVDE,
  input  logic             s_pHSync,
  input  logic             s_pVSync,
  output logic [23:0]      m_pData,
  output logic             m_pVDE,
  output logic             m_pHSync,
  output logic             m_pVSync,
  output logic [X_W-1:0]   box_xmin,
  output logic [X_W-1:0]   box_xmax,
  output logic [X_W-1:0]   box_ymin,
  output logic [X_W-1:0]   box_ymax,
  output logic [2*X_W-1:0] pix_count,
  output logic             motion_det,
  output logic             box_valid,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_SYNC, S_ACTIVE, S_LATCH} state_t;

  localparam logic [X_W-1:0]   C_XSAT    = '1;
  localparam logic [2*X_W-1:0] C_CSAT    = '1;
  localparam logic [2*X_W-1:0] C_MIN_CNT = (2*X_W)'(MIN_PIX);

  state_t             r_state, w_state_nxt;
  logic               r_vde_d, r_vs_d;
  logic [X_W-1:0]     r_x, r_y;
  logic [X_W-1:0]     r_run_xmin, r_run_xmax, r_run_ymin, r_run_ymax;
  logic [2*X_W-1:0]   r_run_cnt;
  logic [X_W-1:0]     r_box_xmin, r_box_xmax, r_box_ymin, r_box_ymax;
  logic [2*X_W-1:0]   r_pix_count;
  logic               r_motion_det, r_box_valid, r_frame_done;
  logic [23:0]        r_m_data;
  logic               r_m_vde, r_m_hs, r_m_vs;

  logic               w_set, w_vs_rise, w_vde_fall, w_latch, w_accum;
  logic [23:0]        w_pix_out;

  assign w_set      = s_pVDE && (s_pData != '0);
  assign w_vs_rise  = s_pVSync && !r_vs_d;
  assign w_vde_fall = !s_pVDE && r_vde_d;
  assign w_latch    = (r_state == S_LATCH);
  // The closing VSync edge cycle is still ACTIVE, so a coincident pixel lands in the old frame.
  assign w_accum    = (r_state == S_ACTIVE) && w_set;

  always_ff @(posedge pclk) begin
    if (rst) r_state <= S_SYNC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC:   if (w_vs_rise) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_vs_rise) w_state_nxt = S_LATCH;
      S_LATCH:  w_state_nxt = S_ACTIVE;
      default:  w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst || w_latch) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (s_pVDE) begin
        if (r_x != C_XSAT) r_x <= r_x + 1'b1;
      end else if (r_vde_d) begin
        r_x <= '0;
      end
      if (w_vs_rise)                          r_y <= '0;
      else if (w_vde_fall && r_y != C_XSAT)   r_y <= r_y + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst || w_latch) begin
      r_run_xmin <= '1;
      r_run_xmax <= '0;
      r_run_ymin <= '1;
      r_run_ymax <= '0;
      r_run_cnt  <= '0;
    end else if (w_accum) begin
      if (r_x < r_run_xmin) r_run_xmin <= r_x;
      if (r_x > r_run_xmax) r_run_xmax <= r_x;
      if (r_y < r_run_ymin) r_run_ymin <= r_y;
      if (r_y > r_run_ymax) r_run_ymax <= r_y;
      if (r_run_cnt != C_CSAT) r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  // An empty frame reports a zero box rather than the all-ones min sentinels.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_box_xmin   <= '0;
      r_box_xmax   <= '0;
      r_box_ymin   <= '0;
      r_box_ymax   <= '0;
      r_pix_count  <= '0;
      r_motion_det <= 1'b0;
      r_box_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_latch;
      if (w_latch) begin
        r_box_xmin   <= (r_run_cnt == '0) ? '0 : r_run_xmin;
        r_box_xmax   <= r_run_xmax;
        r_box_ymin   <= (r_run_cnt == '0) ? '0 : r_run_ymin;
        r_box_ymax   <= r_run_ymax;
        r_pix_count  <= r_run_cnt;
        r_motion_det <= (r_run_cnt >= C_MIN_CNT);
        r_box_valid  <= (r_run_cnt != '0);
      end
    end
  end

`ifdef MOTION_BBOX_OVERLAY_EN
  logic w_on_vedge, w_on_hedge;
  assign w_on_vedge = (r_x == r_box_xmin || r_x == r_box_xmax) &&
                      (r_y >= r_box_ymin) && (r_y <= r_box_ymax);
  assign w_on_hedge = (r_y == r_box_ymin || r_y == r_box_ymax) &&
                      (r_x >= r_box_xmin) && (r_x <= r_box_xmax);
  assign w_pix_out  = !s_pVDE ? 24'h0 :
                      (r_box_valid && (w_on_vedge || w_on_hedge)) ? BOX_COLOR : s_pData;
`else
  assign w_pix_out  = s_pVDE ? s_pData : 24'h0;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vde_d  <= 1'b0;
      r_vs_d   <= 1'b0;
      r_m_data <= '0;
      r_m_vde  <= 1'b0;
      r_m_hs   <= 1'b0;
      r_m_vs   <= 1'b0;
    end else begin
      r_vde_d  <= s_pVDE;
      r_vs_d   <= s_pVSync;
      r_m_data <= w_pix_out;
      r_m_vde  <= s_pVDE;
      r_m_hs   <= s_pHSync;
      r_m_vs   <= s_pVSync;
    end
  end

  assign m_pData    = r_m_data;
  assign m_pVDE     = r_m_vde;
  assign m_pHSync   = r_m_hs;
  assign m_pVSync   = r_m_vs;
  assign box_xmin   = r_box_xmin;
  assign box_xmax   = r_box_xmax;
  assign box_ymin   = r_box_ymin;
  assign box_ymax   = r_box_ymax;
  assign pix_count  = r_pix_count;
  assign motion_det = r_motion_det;
  assign box_valid  = r_box_valid;
  assign frame_done = r_frame_done;

endmodule
